// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I control sequencer: instruction types,
// opcodes, sequencer states and the registered control-word layout.
package rv32i_pkg;

    typedef enum logic [3:0] {
        INST_LOAD  = 4'd0,
        INST_IMM   = 4'd1,
        INST_STORE = 4'd2,
        INST_REG   = 4'd3,
        INST_LUI   = 4'd4,
        INST_AUIPC = 4'd5,
        INST_BRNCH = 4'd6,
        INST_JALR  = 4'd7,
        INST_JAL   = 4'd8
    } inst_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        COMMIT,
        HALT,
        TRAP
    } state_e;

    typedef struct packed {
        inst_type_e  inst_type;
        logic [2:0]  fun3;
        logic        fun7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctrl_word_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational decode of one instruction word into a control word,
// plus legality and system-opcode flags for the sequencer.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_word_t  cw,
    output logic        legal,
    output logic        is_system
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        cw.inst_type = INST_LOAD;
        cw.fun3      = instr[14:12];
        cw.fun7      = 1'b0;
        cw.rd        = instr[11:7];
        cw.rs1       = instr[19:15];
        cw.rs2       = instr[24:20];
        cw.imm       = '0;
        legal        = 1'b1;
        is_system    = 1'b0;
        case (instr[6:0])
            OP_LOAD: begin
                cw.inst_type = INST_LOAD;
                cw.imm       = imm_i;
            end
            OP_IMM: begin
                // only the shift-right-immediate pair carries a fun7 selector
                cw.inst_type = INST_IMM;
                cw.imm       = imm_i;
                cw.fun7      = (instr[14:12] == 3'b101) ? instr[30] : 1'b0;
            end
            OP_STORE: begin
                cw.inst_type = INST_STORE;
                cw.imm       = imm_s;
            end
            OP_REG: begin
                cw.inst_type = INST_REG;
                cw.fun7      = instr[30];
            end
            OP_LUI: begin
                cw.inst_type = INST_LUI;
                cw.imm       = imm_u;
            end
            OP_AUIPC: begin
                cw.inst_type = INST_AUIPC;
                cw.imm       = imm_u;
            end
            OP_BRANCH: begin
                cw.inst_type = INST_BRNCH;
                cw.imm       = imm_b;
            end
            OP_JALR: begin
                cw.inst_type = INST_JALR;
                cw.imm       = imm_i;
            end
            OP_JAL: begin
                cw.inst_type = INST_JAL;
                cw.imm       = imm_j;
            end
            OP_SYSTEM: begin
                is_system = 1'b1;
                legal     = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/commit sequencer for the RV32I core.
// Define CTRL_MISALIGN_TRAP_EN to trap on misaligned next-PC targets.
module rv32i_ctrl_fsm
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned EXEC_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] alu_result,
    input  logic        br_taken,
    output logic [3:0]  instType,
    output logic [2:0]  fun3,
    output logic        fun7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic [31:0] pc,
    output logic        dp_en,
    output logic        retire,
    output logic        halted,
    output logic        trap
);

    localparam int CNT_W = $clog2(EXEC_CYCLES + 1);

    state_e           state;
    logic [31:0]      pc_q;
    logic [31:0]      pc_nxt;
    logic [31:0]      instr_q;
    logic [CNT_W-1:0] cnt;
    ctrl_word_t       cw_q;
    ctrl_word_t       dec_cw;
    logic             dec_legal;
    logic             dec_system;
    logic [31:0]      target;
    logic [31:0]      commit_pc;
    logic             misalign;

    rv32i_imm_gen u_imm_gen (
        .instr     (instr_q),
        .cw        (dec_cw),
        .legal     (dec_legal),
        .is_system (dec_system)
    );

    always_comb begin
        target = pc_q + 32'd4;
        case (cw_q.inst_type)
            INST_JAL:   target = pc_q + cw_q.imm;
            INST_BRNCH: if (br_taken) target = pc_q + cw_q.imm;
            INST_JALR:  target = alu_result & 32'hFFFF_FFFE;
            default:    target = pc_q + 32'd4;
        endcase
    end

`ifdef CTRL_MISALIGN_TRAP_EN
    assign misalign  = |target[1:0];
    assign commit_pc = target;
`else
    assign misalign  = 1'b0;
    assign commit_pc = {target[31:2], 2'b00};
`endif

    // target is resolved on the last EXEC cycle so a misaligned commit can
    // divert to TRAP without ever raising retire
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            pc_q     <= RESET_PC;
            pc_nxt   <= '0;
            instr_q  <= '0;
            cnt      <= '0;
            cw_q     <= '0;
            imem_req <= 1'b0;
            dp_en    <= 1'b0;
            retire   <= 1'b0;
            halted   <= 1'b0;
            trap     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr_q  <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_system) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else if (!dec_legal) begin
                        trap  <= 1'b1;
                        state <= TRAP;
                    end else begin
                        cw_q  <= dec_cw;
                        cnt   <= CNT_W'(EXEC_CYCLES);
                        dp_en <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        dp_en  <= 1'b0;
                        pc_nxt <= commit_pc;
                        if (misalign) begin
                            trap  <= 1'b1;
                            state <= TRAP;
                        end else begin
                            retire <= 1'b1;
                            state  <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    pc_q     <= pc_nxt;
                    retire   <= 1'b0;
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                HALT, TRAP: begin
                    state <= state;
                end
                default: begin
                    trap  <= 1'b1;
                    state <= TRAP;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instType  = cw_q.inst_type;
    assign fun3      = cw_q.fun3;
    assign fun7      = cw_q.fun7;
    assign rd        = cw_q.rd;
    assign rs1       = cw_q.rs1;
    assign rs2       = cw_q.rs2;
    assign imm       = cw_q.imm;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Directed bench for rv32i_ctrl_fsm: fetch timing, decode, PC commit,
// reset behaviour, illegal/system opcodes and misaligned targets.
module tb_rv32i_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] alu_result;
    logic        br_taken;
    logic [3:0]  instType;
    logic [2:0]  fun3;
    logic        fun7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        dp_en;
    logic        retire;
    logic        halted;
    logic        trap;

    int errors;
    int checks;
    logic [31:0] exp_pc;

    localparam logic [31:0] DEC_INSTR [6] = '{32'h402081B3, 32'h40335293, 32'hFFC12283,
                                              32'h00512423, 32'h123453B7, 32'hFFFFF097};
    localparam logic [3:0]  DEC_TYPE  [6] = '{4'd3, 4'd1, 4'd0, 4'd2, 4'd4, 4'd5};
    localparam logic [2:0]  DEC_FUN3  [6] = '{3'd0, 3'd5, 3'd2, 3'd2, 3'd5, 3'd7};
    localparam logic        DEC_FUN7  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [4:0]  DEC_RD    [6] = '{5'd3, 5'd5, 5'd5, 5'd8, 5'd7, 5'd1};
    localparam logic [4:0]  DEC_RS1   [6] = '{5'd1, 5'd6, 5'd2, 5'd2, 5'd8, 5'd31};
    localparam logic [4:0]  DEC_RS2   [6] = '{5'd2, 5'd3, 5'd28, 5'd5, 5'd3, 5'd31};
    localparam logic [31:0] DEC_IMM   [6] = '{32'h0, 32'h403, 32'hFFFFFFFC,
                                              32'h8, 32'h12345000, 32'hFFFFF000};

    rv32i_ctrl_fsm #(
        .RESET_PC    (32'h0000_0000),
        .EXEC_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_result (alu_result),
        .br_taken   (br_taken),
        .instType   (instType),
        .fun3       (fun3),
        .fun7       (fun7),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .pc         (pc),
        .dp_en      (dp_en),
        .retire     (retire),
        .halted     (halted),
        .trap       (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entered in the first cycle of a fetch (imem_req high). Cycle 1 is that
    // cycle. Leaves in the next fetch cycle after a retire, or in place when
    // halted/trap appears, or after a bounded number of cycles.
    task automatic run_instr(input logic [31:0] instr, input int waits, input logic br,
                             input logic [31:0] alu, output int retire_cyc,
                             output int dp_cnt, output int addr_cnt);
        int cyc;
        int wleft;
        logic [31:0] start_addr;
        cyc        = 1;
        wleft      = waits;
        retire_cyc = 0;
        dp_cnt     = 0;
        addr_cnt   = 0;
        start_addr = imem_addr;
        br_taken   = br;
        alu_result = alu;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == start_addr) addr_cnt++;
            if (dp_en) dp_cnt++;
            if (retire) begin
                retire_cyc = cyc;
                break;
            end
            if (halted || trap) break;
            if (imem_req && wleft == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = instr;
            end else begin
                imem_ack = 1'b0;
                if (imem_req) wleft--;
            end
            @(posedge clk); #1;
            cyc++;
        end
        imem_ack = 1'b0;
        if (retire_cyc != 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        imem_ack = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000007F;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({imem_req, dp_en, retire, halted, trap} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {imem_req, dp_en, retire, halted, trap});
        end
        checks++;
        if (pc !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got pc=%h addr=%h expected 0", pc, imem_addr);
        end
        checks++;
        if (instType !== 4'd0 || imm !== 32'h0 || rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_cw: got type=%0d imm=%h rd=%0d expected 0", instType, imm, rd);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || trap !== 1'b0) begin
            errors++;
            $display("FAIL req_after_reset: got req=%b trap=%b expected 1 0", imem_req, trap);
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_addi();
        int rc, dc, ac;
        run_instr(32'h00500093, 0, 1'b0, 32'h0, rc, dc, ac);
        checks++;
        if (rc !== 6) begin
            errors++;
            $display("FAIL addi_latency: got %0d expected 6", rc);
        end
        checks++;
        if (dc !== 3) begin
            errors++;
            $display("FAIL addi_dp_en: got %0d expected 3", dc);
        end
        checks++;
        if ({instType, rd, rs1, fun3, fun7} !== {4'd1, 5'd1, 5'd0, 3'd0, 1'b0} || imm !== 32'd5) begin
            errors++;
            $display("FAIL addi_decode: got type=%0d rd=%0d rs1=%0d imm=%h expected 1 1 0 5",
                     instType, rd, rs1, imm);
        end
        checks++;
        if (pc !== 32'h4 || imem_addr !== 32'h4 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL addi_pc: got pc=%h addr=%h req=%b expected 4 4 1", pc, imem_addr, imem_req);
        end
    endtask

    task automatic test_wait_states();
        int rc, dc, ac;
        run_instr(32'h00500093, 2, 1'b0, 32'h0, rc, dc, ac);
        checks++;
        if (ac !== 3) begin
            errors++;
            $display("FAIL wait_addr_stable: got %0d expected 3", ac);
        end
        checks++;
        if (rc !== 8) begin
            errors++;
            $display("FAIL wait_latency: got %0d expected 8", rc);
        end
        checks++;
        if (pc !== 32'h8) begin
            errors++;
            $display("FAIL wait_pc: got %h expected 00000008", pc);
        end
    endtask

    task automatic test_decode();
        int rc, dc, ac;
        exp_pc = 32'h8;
        for (int unsigned i = 0; i < 6; i++) begin
            run_instr(DEC_INSTR[i], 0, 1'b0, 32'h0, rc, dc, ac);
            exp_pc = exp_pc + 32'd4;
            checks++;
            if ({instType, fun3, fun7, rd, rs1, rs2} !==
                {DEC_TYPE[i], DEC_FUN3[i], DEC_FUN7[i], DEC_RD[i], DEC_RS1[i], DEC_RS2[i]}) begin
                errors++;
                $display("FAIL decode_fields[%0d]: got %0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d",
                         i, instType, fun3, fun7, rd, rs1, rs2, DEC_TYPE[i], DEC_FUN3[i],
                         DEC_FUN7[i], DEC_RD[i], DEC_RS1[i], DEC_RS2[i]);
            end
            checks++;
            if (imm !== DEC_IMM[i]) begin
                errors++;
                $display("FAIL decode_imm[%0d]: got %h expected %h", i, imm, DEC_IMM[i]);
            end
            checks++;
            if (pc !== exp_pc || rc !== 6) begin
                errors++;
                $display("FAIL decode_commit[%0d]: got pc=%h lat=%0d expected %h 6", i, pc, rc, exp_pc);
            end
        end
    endtask

    task automatic test_branch();
        int rc, dc, ac;
        run_instr(32'hFE000CE3, 0, 1'b1, 32'h0, rc, dc, ac);
        checks++;
        if (instType !== 4'd6 || imm !== 32'hFFFFFFF8) begin
            errors++;
            $display("FAIL beq_decode: got type=%0d imm=%h expected 6 fffffff8", instType, imm);
        end
        checks++;
        if (pc !== 32'h18) begin
            errors++;
            $display("FAIL beq_taken_pc: got %h expected 00000018", pc);
        end
        run_instr(32'h0080006F, 0, 1'b0, 32'h0, rc, dc, ac);
        checks++;
        if (pc !== 32'h20) begin
            errors++;
            $display("FAIL jal8_pc: got %h expected 00000020", pc);
        end
        run_instr(32'hFE000CE3, 0, 1'b0, 32'h0, rc, dc, ac);
        checks++;
        if (pc !== 32'h24) begin
            errors++;
            $display("FAIL beq_not_taken_pc: got %h expected 00000024", pc);
        end
    endtask

    task automatic test_jump();
        int rc, dc, ac;
        run_instr(32'h00008067, 0, 1'b0, 32'h101, rc, dc, ac);
        checks++;
        if (instType !== 4'd7 || pc !== 32'h100) begin
            errors++;
            $display("FAIL jalr_pc: got type=%0d pc=%h expected 7 00000100", instType, pc);
        end
        run_instr(32'h00008067, 0, 1'b0, 32'h11, rc, dc, ac);
        checks++;
        if (pc !== 32'h10) begin
            errors++;
            $display("FAIL jalr_back_pc: got %h expected 00000010", pc);
        end
        run_instr(32'h0010006F, 0, 1'b0, 32'h0, rc, dc, ac);
        checks++;
        if (instType !== 4'd8 || imm !== 32'h800 || pc !== 32'h810) begin
            errors++;
            $display("FAIL jal_pc: got type=%0d imm=%h pc=%h expected 8 00000800 00000810",
                     instType, imm, pc);
        end
    endtask

    task automatic test_reset_exec();
        imem_ack   = 1'b1;
        imem_rdata = 32'h00500093;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dp_en !== 1'b1 || pc !== 32'h810) begin
            errors++;
            $display("FAIL exec_entry: got dp_en=%b pc=%h expected 1 00000810", dp_en, pc);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dp_en !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0 || instType !== 4'd0) begin
            errors++;
            $display("FAIL reset_in_exec: got dp_en=%b req=%b pc=%h type=%0d expected 0 0 0 0",
                     dp_en, imem_req, pc, instType);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL refetch_after_reset: got req=%b addr=%h expected 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_misalign();
        int rc, dc, ac;
        run_instr(32'h00008067, 0, 1'b0, 32'h102, rc, dc, ac);
`ifdef CTRL_MISALIGN_TRAP_EN
        checks++;
        if (trap !== 1'b1 || rc !== 0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL misalign_trap: got trap=%b retire_cyc=%0d pc=%h expected 1 0 0", trap, rc, pc);
        end
`else
        checks++;
        if (trap !== 1'b0 || rc !== 6 || pc !== 32'h100) begin
            errors++;
            $display("FAIL misalign_force: got trap=%b retire_cyc=%0d pc=%h expected 0 6 00000100",
                     trap, rc, pc);
        end
`endif
    endtask

    task automatic test_illegal();
        int rc, dc, ac;
        apply_reset();
        run_instr(32'h0000007F, 0, 1'b0, 32'h0, rc, dc, ac);
        checks++;
        if (trap !== 1'b1 || halted !== 1'b0 || rc !== 0) begin
            errors++;
            $display("FAIL illegal_trap: got trap=%b halted=%b retire_cyc=%0d expected 1 0 0", trap, halted, rc);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h00500093;
        repeat (5) begin
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;
        checks++;
        if (trap !== 1'b1 || imem_req !== 1'b0 || dp_en !== 1'b0 || pc !== 32'h0 || instType !== 4'd0) begin
            errors++;
            $display("FAIL trap_frozen: got trap=%b req=%b dp_en=%b pc=%h type=%0d expected 1 0 0 0 0",
                     trap, imem_req, dp_en, pc, instType);
        end
    endtask

    task automatic test_halt();
        int rc, dc, ac;
        apply_reset();
        run_instr(32'h00500093, 0, 1'b0, 32'h0, rc, dc, ac);
        run_instr(32'h00000073, 0, 1'b0, 32'h0, rc, dc, ac);
        checks++;
        if (halted !== 1'b1 || trap !== 1'b0) begin
            errors++;
            $display("FAIL ecall_halt: got halted=%b trap=%b expected 1 0", halted, trap);
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || instType !== 4'd1 || pc !== 32'h4) begin
            errors++;
            $display("FAIL halt_frozen: got halted=%b req=%b type=%0d pc=%h expected 1 0 1 00000004",
                     halted, imem_req, instType, pc);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        exp_pc     = '0;
        rst        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        alu_result = '0;
        br_taken   = 1'b0;
        test_reset();
        test_addi();
        test_wait_states();
        test_decode();
        test_branch();
        test_jump();
        test_reset_exec();
        test_misalign();
        test_illegal();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_ctrl_fsm.md
# rv32i_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. It fetches instructions over a request/acknowledge instruction-memory port and decodes them into the datapath control word (instType, fun3, fun7, rd, rs1, rs2, imm, pc). It holds that word stable while the registered datapath settles, then commits the next PC from the datapath's ALU result and branch outcome. It sits between instruction memory and the datapath; the datapath's control-word inputs are driven solely by this block.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- EXEC_CYCLES, 3: cycles the control word is held in EXEC (≥1); covers datapath register depth.
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address (= pc).
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  32  instruction word.
- alu_result  input  32  datapath ALU output (JALR target).
- br_taken  input  1  datapath branch condition true.
- instType  output  4  load 0, imm 1, store 2, reg 3, lui 4, auipc 5, brnch 6, jalr 7, jal 8.
- fun3  output  3  instr[14:12].
- fun7  output  1  instr[30] for reg, and for imm with fun3=101; else 0.
- rd, rs1, rs2  output  5 each  register indices.
- imm  output  32  sign-extended immediate per format (I/S/B/U/J); 0 for reg.
- pc  output  32  address of the current instruction.
- dp_en  output  1  datapath step enable, high only in EXEC.
- retire  output  1  one-cycle pulse per committed instruction.
- halted  output  1  ECALL/EBREAK reached (opcode 1110011).
- trap  output  1  illegal opcode (or misaligned target, see Configuration).

## Operation
- States: FETCH, DECODE, EXEC, COMMIT, HALT, TRAP.
- FETCH: imem_req=1, imem_addr=pc held until imem_req&&imem_ack; imem_rdata captured in that cycle → DECODE.
- DECODE: opcode mapped (0000011→0, 0010011→1, 0100011→2, 0110011→3, 0110111→4, 0010111→5, 1100011→6, 1100111→7, 1101111→8); control word registered. 1110011 → HALT; any other opcode → TRAP; else → EXEC.
- EXEC: dp_en=1 for exactly EXEC_CYCLES cycles (down-counter); br_taken and alu_result sampled on the last cycle → COMMIT.
- COMMIT: pc ← pc+imm (jal; brnch with br_taken), {alu_result[31:1],1'b0} (jalr), else pc+4; retire=1; → FETCH.
- HALT/TRAP: absorbing; control word frozen; only reset exits.
- Arithmetic 32-bit modulo; pc wraps 32'hFFFF_FFFC+4 → 0 silently.

## Timing
- Reset (async assert): state=FETCH, pc=RESET_PC, all other outputs 0, counter 0. imem_req rises first rising edge after deassert.
- Instruction latency with zero-wait ack: 1+1+EXEC_CYCLES+1 = 6 cycles default; each imem wait cycle adds 1.
- Control word changes only on DECODE→EXEC edge; stable through EXEC and COMMIT.
- Reset mid-fetch: request dropped immediately; in-flight ack after reset ignored unless new request is up.
- imem_ack without imem_req ignored.

## Configuration
- CTRL_MISALIGN_TRAP_EN defined: a COMMIT target with bits[1:0]≠0 → TRAP instead of FETCH, pc keeps faulting instruction address, retire not pulsed.
- Undefined: target bits[1:0] forced to 00, execution continues.

## Structure
- Shared package rv32i_pkg: instType encodings (INST_LOAD…INST_JAL), opcode constants, state enum.
- One sub-module: rv32i_imm_gen (combinational immediate/fields decode from instr word).

## Test plan
- addi x1,x0,5 (32'h00500093) at pc 0, ack immediate → instType=1, rd=1, rs1=0, imm=5, dp_en 3 cycles, retire at cycle 6, pc=4.
- Two imem wait cycles before ack → addr stable 3 cycles, retire at cycle 8.
- beq with br_taken=1, imm=-8, pc=0x20 → pc=0x18; br_taken=0 → pc=0x24.
- jalr, alu_result=0x101 → pc=0x100; jal imm=0x800 from 0x10 → 0x810.
- Opcode 7'b1111111 → trap=1, state frozen; 32'h00000073 → halted=1.
- jalr alu_result=0x102: with CTRL_MISALIGN_TRAP_EN → trap=1, pc unchanged; without → pc=0x100. Reset during EXEC → pc=RESET_PC, dp_en=0 immediately.
